// File: rtl/gs_pkg.sv
// Shared definitions for the 3x3 Gaussian filter and its window sequencing controller.
// Holds the frame-state encoding and the default frame geometry.
package gs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned COL_NUM_DEF = 640;
  localparam int unsigned ROW_NUM_DEF = 480;
  localparam int unsigned COL_W_DEF   = 10;
  localparam int unsigned ROW_W_DEF   = 9;
  localparam int unsigned LAT_DEF     = 1;

endpackage

// File: rtl/gs_win_ctrl_sig_dly.sv
// Fixed-depth register delay line with asynchronous clear.
// DEPTH=0 degenerates to a wire.
module sig_dly #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n};
      assign q = d;
    end else begin : g_regs
      logic [W-1:0] stage_reg [DEPTH];

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [W-1:0] stage_in;
        if (gi == 0) begin : g_first
          assign stage_in = d;
        end else begin : g_next
          assign stage_in = stage_reg[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            stage_reg[gi] <= '0;
          end else begin
            stage_reg[gi] <= stage_in;
          end
        end
      end

      assign q = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/gs_win_ctrl.sv
// Raster position tracker for the 3x3 Gaussian filter: flags complete windows,
// regenerates window-aligned sop/eop and reports frame-length / framing errors.
module gs_win_ctrl
  import gs_pkg::*;
#(
  parameter int unsigned COL_NUM = COL_NUM_DEF,
  parameter int unsigned ROW_NUM = ROW_NUM_DEF,
  parameter int unsigned COL_W   = COL_W_DEF,
  parameter int unsigned ROW_W   = ROW_W_DEF,
  parameter int unsigned LAT     = LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  input  logic             din_sop,
  input  logic             din_eop,
  output logic             win_vld,
  output logic             win_sop,
  output logic             win_eop,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             frm_done,
  output logic             err_sop,
  output logic             err_len
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_NUM - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_NUM - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam int unsigned      WIN_W    = 3 + ROW_W + COL_W;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;

  logic             beat_act;
  logic [COL_W-1:0] beat_col;
  logic [ROW_W-1:0] beat_row;
  logic             is_last;
  logic             eop_ok;
  logic             win_ok;
  logic             done_next, err_sop_next, err_len_next;

  logic             done_reg, err_sop_reg, err_len_reg;
  logic             wv_reg, ws_reg, we_reg;
  logic [ROW_W-1:0] wr_reg;
  logic [COL_W-1:0] wc_reg;
  logic [WIN_W-1:0] dly_q;

  // A sop beat always lands on (0,0), whatever the state, so restart wins over continuation.
  always_comb begin
    state_next   = state_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    beat_act     = 1'b0;
    beat_col     = '0;
    beat_row     = '0;
    is_last      = 1'b0;
    eop_ok       = 1'b0;
    done_next    = 1'b0;
    err_sop_next = 1'b0;
    err_len_next = 1'b0;

    if (din_vld) begin
      if (din_sop) begin
        beat_act     = 1'b1;
        err_sop_next = (state_reg == RUN);
      end else if (state_reg == RUN) begin
        beat_act = 1'b1;
        beat_col = col_reg;
        beat_row = row_reg;
      end
    end

    if (beat_act) begin
      is_last = (beat_row == ROW_LAST) && (beat_col == COL_LAST);
      if (din_eop || is_last) begin
        state_next = IDLE;
        col_next   = '0;
        row_next   = '0;
        if (din_eop && is_last) begin
          eop_ok    = 1'b1;
          done_next = 1'b1;
        end else begin
          err_len_next = 1'b1;
        end
      end else begin
        state_next = RUN;
        if (beat_col == COL_LAST) begin
          col_next = '0;
          row_next = beat_row + 1'b1;
        end else begin
          col_next = beat_col + 1'b1;
          row_next = beat_row;
        end
      end
    end
  end

  assign win_ok = beat_act && (beat_row >= ROW_TWO) && (beat_col >= COL_TWO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      done_reg    <= 1'b0;
      err_sop_reg <= 1'b0;
      err_len_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      done_reg    <= done_next;
      err_sop_reg <= err_sop_next;
      err_len_reg <= err_len_next;
    end
  end

  // Centre coordinates are only refreshed by complete windows and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wv_reg <= 1'b0;
      ws_reg <= 1'b0;
      we_reg <= 1'b0;
      wr_reg <= '0;
      wc_reg <= '0;
    end else begin
      wv_reg <= win_ok;
      ws_reg <= win_ok && (beat_row == ROW_TWO) && (beat_col == COL_TWO);
      we_reg <= win_ok && eop_ok;
      if (win_ok) begin
        wr_reg <= beat_row - 1'b1;
        wc_reg <= beat_col - 1'b1;
      end
    end
  end

  sig_dly #(
    .W     (WIN_W),
    .DEPTH (LAT - 1)
  ) u_sig_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({wv_reg, ws_reg, we_reg, wr_reg, wc_reg}),
    .q     (dly_q)
  );

  assign {win_vld, win_sop, win_eop, win_row, win_col} = dly_q;

  assign busy     = (state_reg == RUN);
  assign frm_done = done_reg;
  assign err_sop  = err_sop_reg;
  assign err_len  = err_len_reg;

endmodule

// File: tb/tb_gs_win_ctrl.sv
// Randomised and directed bench for gs_win_ctrl on a 4x3 frame with LAT=2, checked
// against a pixel-index model of the frame rules.
module tb_gs_win_ctrl;

  localparam int C   = 4;
  localparam int R   = 3;
  localparam int CW  = 3;
  localparam int RW  = 2;
  localparam int LAT = 2;
  localparam int NPIX = C * R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din_vld = 1'b0;
  logic          din_sop = 1'b0;
  logic          din_eop = 1'b0;
  logic          win_vld, win_sop, win_eop;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy, frm_done, err_sop, err_len;

  gs_win_ctrl #(
    .COL_NUM (C),
    .ROW_NUM (R),
    .COL_W   (CW),
    .ROW_W   (RW),
    .LAT     (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .win_vld  (win_vld),
    .win_sop  (win_sop),
    .win_eop  (win_eop),
    .win_row  (win_row),
    .win_col  (win_col),
    .busy     (busy),
    .frm_done (frm_done),
    .err_sop  (err_sop),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit s;
    bit e;
    int r;
    int c;
  } win_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Model: frame membership plus linear index of the next expected pixel.
  bit   m_in;
  int   m_k;
  int   hold_r, hold_c;
  win_t wq[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    win_t z;
    z = '{v: 0, s: 0, e: 0, r: 0, c: 0};
    m_in   = 0;
    m_k    = 0;
    hold_r = 0;
    hold_c = 0;
    wq.delete();
    for (int i = 0; i < LAT - 1; i++) wq.push_back(z);
  endtask

  task automatic check_outs(input win_t w, input bit ed, input bit es, input bit el, input bit eb);
    check_val("win_vld",  32'(win_vld),  32'(w.v));
    check_val("win_sop",  32'(win_sop),  32'(w.s));
    check_val("win_eop",  32'(win_eop),  32'(w.e));
    check_val("win_row",  32'(win_row),  32'(w.r));
    check_val("win_col",  32'(win_col),  32'(w.c));
    check_val("busy",     32'(busy),     32'(eb));
    check_val("frm_done", 32'(frm_done), 32'(ed));
    check_val("err_sop",  32'(err_sop),  32'(es));
    check_val("err_len",  32'(err_len),  32'(el));
  endtask

  task automatic beat(input bit v, input bit s, input bit e);
    win_t w, x;
    bit   ed, es, el, act, last;
    int   b, r, c;
    @(negedge clk);
    din_vld = v;
    din_sop = s;
    din_eop = e;
    @(posedge clk);
    #1;
    cyc++;
    ed = 0; es = 0; el = 0; act = 0;
    w = '{v: 0, s: 0, e: 0, r: 0, c: 0};
    if (v) begin
      if (s) begin
        es   = m_in;
        m_k  = 0;
        act  = 1;
      end else if (m_in) begin
        act = 1;
      end
    end
    if (act) begin
      b    = m_k;
      r    = b / C;
      c    = b % C;
      last = (b == NPIX - 1);
      if (r >= 2 && c >= 2) begin
        w.v    = 1;
        w.s    = (r == 2 && c == 2);
        w.e    = last && e;
        hold_r = r - 1;
        hold_c = c - 1;
      end
      if (e || last) begin
        m_in = 0;
        if (e && last) ed = 1;
        else el = 1;
      end else begin
        m_in = 1;
        m_k  = b + 1;
      end
    end
    w.r = hold_r;
    w.c = hold_c;
    wq.push_back(w);
    x = wq.pop_front();
    $display("cyc=%0d in v/s/e=%0b%0b%0b out win=%0b%0b%0b (%0d,%0d) busy=%0b done=%0b es=%0b el=%0b",
             cyc, v, s, e, win_vld, win_sop, win_eop, win_row, win_col, busy, frm_done, err_sop, err_len);
    check_outs(x, ed, es, el, m_in);
  endtask

  task automatic apply_reset();
    win_t z;
    z = '{v: 0, s: 0, e: 0, r: 0, c: 0};
    @(negedge clk);
    rst_n   = 1'b0;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    #1;
    model_reset();
    check_outs(z, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outs(z, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, 0);
  endtask

  initial begin
    bit v, s, e;
    model_reset();
    apply_reset();

    // Contiguous frame.
    for (int i = 0; i < NPIX; i++) beat(1, i == 0, i == NPIX - 1);
    idle(3);

    // Gapped frame.
    for (int i = 0; i < NPIX; i++) begin
      beat(1, i == 0, i == NPIX - 1);
      beat(0, 0, 0);
    end
    idle(3);

    // Early eop, then stray non-sop beats.
    for (int i = 0; i < 8; i++) beat(1, i == 0, i == 7);
    for (int i = 0; i < 3; i++) beat(1, 0, 0);
    idle(3);

    // Restart mid-frame, then a complete frame.
    for (int i = 0; i < 5; i++) beat(1, i == 0, 0);
    for (int i = 0; i < NPIX; i++) beat(1, i == 0, i == NPIX - 1);
    idle(3);

    // Missing eop, then a 13th beat.
    for (int i = 0; i < NPIX; i++) beat(1, i == 0, 0);
    beat(1, 0, 0);
    idle(3);

    // Back-to-back frames and sop+eop together.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NPIX; i++) beat(1, i == 0, i == NPIX - 1);
    beat(1, 1, 1);
    for (int i = 0; i < 3; i++) beat(1, i == 0, 0);
    beat(1, 1, 1);
    idle(3);

    // Reset with a window in flight.
    for (int i = 0; i < 11; i++) beat(1, i == 0, 0);
    apply_reset();
    beat(1, 0, 0);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      v = ($urandom_range(0, 99) < 70);
      if (!m_in) s = ($urandom_range(0, 99) < 30);
      else       s = ($urandom_range(0, 99) < 2);
      if (m_in && m_k == NPIX - 1 && !s) e = ($urandom_range(0, 99) < 85);
      else                               e = ($urandom_range(0, 99) < 3);
      beat(v, s, e);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
